hash_lookup: RTL

//  Read side of the open-addressed hash table: searches the table for a key and reports hit/miss.

---
 rtl/hash_lookup.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hash_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hash_lookup                                                  |
// | Description : Read side of an open-addressed hash table. Linear-probes      |
// |               from home slot num % TABLE_SIZE and reports hit/miss.         |
// |               Optional hit/miss counters: define HASH_LOOKUP_STATS_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hash_lookup #(
    parameter int NUM_SIZE   = 10,
    parameter int TABLE_SIZE = 10,
    parameter int INDEX_BITS = 4
`ifdef HASH_LOOKUP_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [NUM_SIZE-1:0]   num,
    output logic                  tbl_rd_en,
    output logic [INDEX_BITS-1:0] tbl_rd_addr,
    input  logic [NUM_SIZE-1:0]   tbl_rd_data,
    input  logic                  tbl_rd_occ,
    output logic                  busy,
    output logic                  cmplt,
    output logic                  found,
    output logic [INDEX_BITS-1:0] found_idx
`ifdef HASH_LOOKUP_STATS_EN
    ,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
`endif
);

    localparam logic [1:0]            c_MODE_LOOKUP  = 2'b10;
    localparam logic [NUM_SIZE-1:0]   c_TABLE_SIZE_N = NUM_SIZE'(TABLE_SIZE);
    localparam logic [INDEX_BITS-1:0] c_LAST_IDX     = INDEX_BITS'(TABLE_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [NUM_SIZE-1:0]   r_key, w_key;
    logic [INDEX_BITS-1:0] r_idx, w_idx;
    logic [INDEX_BITS-1:0] r_home, w_home;
    logic [INDEX_BITS-1:0] r_probe, w_probe;
    logic                  r_found, w_found;
    logic [INDEX_BITS-1:0] r_found_idx, w_found_idx;
    logic                  r_rd_en;
    logic [INDEX_BITS-1:0] r_rd_addr;
    logic                  r_busy;
    logic                  r_cmplt;
    logic [INDEX_BITS-1:0] w_home_calc;

    assign w_home_calc = INDEX_BITS'(num % c_TABLE_SIZE_N);

    always_comb begin
        w_state_nxt = r_state;
        w_key       = r_key;
        w_idx       = r_idx;
        w_home      = r_home;
        w_probe     = r_probe;
        w_found     = r_found;
        w_found_idx = r_found_idx;
        case (r_state)
            S_IDLE: begin
                if (mode == c_MODE_LOOKUP) begin
                    w_key       = num;
                    w_idx       = w_home_calc;
                    w_home      = w_home_calc;
                    w_probe     = '0;
                    w_found     = 1'b0;
                    w_found_idx = '0;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: w_state_nxt = S_CMP;
            S_CMP: begin
                if (!tbl_rd_occ) begin
                    w_found_idx = r_idx;
                    w_state_nxt = S_DONE;
                end else if (tbl_rd_data == r_key) begin
                    w_found     = 1'b1;
                    w_found_idx = r_idx;
                    w_state_nxt = S_DONE;
                end else if (r_probe == c_LAST_IDX) begin
                    // Every slot visited without a match: report the home slot.
                    w_found_idx = r_home;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx       = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
                    w_probe     = r_probe + 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobe/address/status outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_key       <= '0;
            r_idx       <= '0;
            r_home      <= '0;
            r_probe     <= '0;
            r_found     <= 1'b0;
            r_found_idx <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_cmplt     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key       <= w_key;
            r_idx       <= w_idx;
            r_home      <= w_home;
            r_probe     <= w_probe;
            r_found     <= w_found;
            r_found_idx <= w_found_idx;
            r_rd_en     <= (w_state_nxt == S_READ);
            r_rd_addr   <= (w_state_nxt == S_READ) ? w_idx : '0;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_cmplt     <= (w_state_nxt == S_DONE);
        end
    end

    assign tbl_rd_en   = r_rd_en;
    assign tbl_rd_addr = r_rd_addr;
    assign busy        = r_busy;
    assign cmplt       = r_cmplt;
    assign found       = r_found;
    assign found_idx   = r_found_idx;

`ifdef HASH_LOOKUP_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_DONE) begin
            if (r_found) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire
